// File: rtl/alu_sel_if.sv
// alu_sel_if: opcode-in / select-out handshake bundle between control and the ALU selector.
// Carries sel_par only when ALU_SEL_PARITY_EN is defined.
interface alu_sel_if #(
    parameter int SEL_W = 4,
    parameter int OP_W  = 3
);
    logic             op_valid;
    logic [OP_W-1:0]  op_code;
    logic             op_ready;
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic             sel_last;
    logic             sel_ready;
    logic             op_err;
`ifdef ALU_SEL_PARITY_EN
    logic             sel_par;
    modport master (output op_valid, op_code, sel_ready,
                    input  op_ready, sel_valid, sel, sel_last, op_err, sel_par);
    modport slave  (input  op_valid, op_code, sel_ready,
                    output op_ready, sel_valid, sel, sel_last, op_err, sel_par);
`else
    modport master (output op_valid, op_code, sel_ready,
                    input  op_ready, sel_valid, sel, sel_last, op_err);
    modport slave  (input  op_valid, op_code, sel_ready,
                    output op_ready, sel_valid, sel, sel_last, op_err);
`endif
endinterface

// File: rtl/alu_sel_encoder.sv
// alu_sel_encoder: turns abstract ALU opcodes into one or two 4-bit selector beats.
// Optional even-parity output sel_par enabled by defining ALU_SEL_PARITY_EN.
module alu_sel_encoder #(
    parameter int SEL_W = 4,
    parameter int OP_W  = 3
) (
    input  logic    clk,
    input  logic    rst,
    alu_sel_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;
    state_t           state, nxt_state;
    logic             two, nxt_two;
    logic [SEL_W-1:0] nxt_sel, first_code;
    logic             nxt_last, nxt_err;
    logic             accept, legal, is_two, advance, to_second;
    // Both two-beat ops finish with B + 1, so only the first code depends on the opcode.
    always_comb begin
        accept     = state == IDLE && bus.op_valid;
        legal      = bus.op_code != {OP_W{1'b1}};
        is_two     = bus.op_code == OP_W'(5) || bus.op_code == OP_W'(6);
        first_code = bus.op_code == OP_W'(5) ? '0 :
                     bus.op_code == OP_W'(6) ? SEL_W'(1) : SEL_W'(bus.op_code);
        advance    = state != IDLE && bus.sel_ready;
        to_second  = advance && state == BEAT1 && two;
        nxt_state  = accept && legal ? BEAT1 : to_second ? BEAT2 : advance ? IDLE : state;
        nxt_sel    = accept && legal ? first_code : to_second ? SEL_W'(1) : bus.sel;
        nxt_last   = accept && legal ? !is_two : to_second ? 1'b1 : bus.sel_last;
        nxt_two    = accept && legal ? is_two : two;
        nxt_err    = accept && !legal;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            two           <= 1'b0;
            bus.sel       <= '0;
            bus.sel_last  <= 1'b0;
            bus.sel_valid <= 1'b0;
            bus.op_ready  <= 1'b1;
            bus.op_err    <= 1'b0;
`ifdef ALU_SEL_PARITY_EN
            bus.sel_par   <= 1'b0;
`endif
        end else begin
            state         <= nxt_state;
            two           <= nxt_two;
            bus.sel       <= nxt_sel;
            bus.sel_last  <= nxt_last;
            bus.sel_valid <= nxt_state != IDLE;
            bus.op_ready  <= nxt_state == IDLE;
            bus.op_err    <= nxt_err;
`ifdef ALU_SEL_PARITY_EN
            bus.sel_par   <= ^{nxt_sel, nxt_last};
`endif
        end
    end
endmodule

// File: tb/tb_alu_sel_encoder.sv
// tb_alu_sel_encoder: directed plus random stimulus against a queue-of-beats reference model.
module tb_alu_sel_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [4:0] q[$];
    logic err_exp = 1'b0;

    alu_sel_if #(.SEL_W(4), .OP_W(3)) bus ();
    alu_sel_encoder #(.SEL_W(4), .OP_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("op_ready", 8'(bus.op_ready), 8'(q.size() == 0));
        check("sel_valid", 8'(bus.sel_valid), 8'(q.size() != 0));
        check("op_err", 8'(bus.op_err), 8'(err_exp));
        if (q.size() != 0) begin
            check("sel", 8'(bus.sel), 8'(q[0][4:1]));
            check("sel_last", 8'(bus.sel_last), 8'(q[0][0]));
`ifdef ALU_SEL_PARITY_EN
            check("sel_par", 8'(bus.sel_par), 8'(^q[0]));
`endif
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare 1 time unit later.
    task automatic step(input logic v, input logic [2:0] c, input logic r);
        int op;
        bus.op_valid  = v;
        bus.op_code   = c;
        bus.sel_ready = r;
        @(posedge clk);
        err_exp = 1'b0;
        op = int'(c);
        if (q.size() != 0) begin
            if (r) void'(q.pop_front());
        end else if (v) begin
            if (op == 7) err_exp = 1'b1;
            else if (op == 5) begin q.push_back({4'd0, 1'b0}); q.push_back({4'd1, 1'b1}); end
            else if (op == 6) begin q.push_back({4'd1, 1'b0}); q.push_back({4'd1, 1'b1}); end
            else q.push_back({4'(op), 1'b1});
        end
        #1;
        check_outputs();
    endtask

    // Asserts reset off-edge, checks the immediate clear, releases it off-edge with sel_ready high.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_sel_valid", 8'(bus.sel_valid), 8'd0);
        check("rst_sel", 8'(bus.sel), 8'd0);
        check("rst_sel_last", 8'(bus.sel_last), 8'd0);
        check("rst_op_err", 8'(bus.op_err), 8'd0);
        q.delete();
        err_exp = 1'b0;
        @(posedge clk);
        #2;
        bus.sel_ready = 1'b1;
        bus.op_valid  = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'd0;
        bus.sel_ready = 1'b1;
        #12;
        do_reset();
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd3, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd5, 1'b1);
        step(1'b1, 3'd2, 1'b1);
        step(1'b1, 3'd2, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd6, 1'b0);
        repeat (3) step(1'b1, 3'd4, 1'b0);
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd7, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd5, 1'b0);
        do_reset();
        step(1'b1, 3'd4, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd2, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd1, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
